// File: rtl/cam_window_capture.sv
// Camera capture front end: tracks raster position, crops/decimates a window and
// writes RGB565 or grayscale pixels to a frame buffer, with frame sync and freeze.
module cam_window_capture #(
  parameter int SRC_W     = 640,
  parameter int SRC_H     = 480,
  parameter int WIN_W     = 256,
  parameter int WIN_H     = 256,
  parameter int X_OFF     = 0,
  parameter int Y_OFF     = 0,
  parameter int DECIM     = 1,
  parameter int BYTE_SWAP = 0,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  input  logic [15:0]       p_data,
  input  logic              f_done,
  input  logic              gray_en,
  input  logic              freeze,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [15:0]       w_data,
  output logic              frame_ready,
  output logic              frame_ok,
  output logic              frozen,
  output logic              err_overflow
);

  localparam int HW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int VW = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam logic [31:0] X_LO  = 32'(X_OFF);
  localparam logic [31:0] X_HI  = 32'(X_OFF + WIN_W * DECIM);
  localparam logic [31:0] Y_LO  = 32'(Y_OFF);
  localparam logic [31:0] Y_HI  = 32'(Y_OFF + WIN_H * DECIM);
  localparam logic [31:0] DMASK = 32'(DECIM - 1);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    CAPTURE = 2'd1,
    FROZEN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row_base;
  logic              last_seen;
  logic              ovf_frame;
  logic              gray_q;

  // p_valid and f_done are single-cycle strobes with no backpressure: every
  // strobe seen on a rising edge is consumed in that same cycle.
  logic [31:0] h32, v32;
  logic        col_hit, row_hit, at_h_end, at_v_end;
  logic        active, accept, ovf_pix, hit, frame_end, seen_now, ovf_now;

  assign h32      = 32'(h);
  assign v32      = 32'(v);
  assign col_hit  = (h32 >= X_LO) && (h32 < X_HI) && (((h32 - X_LO) & DMASK) == 32'd0);
  assign row_hit  = (v32 >= Y_LO) && (v32 < Y_HI) && (((v32 - Y_LO) & DMASK) == 32'd0);
  assign at_h_end = (h == HW'(SRC_W - 1));
  assign at_v_end = (v == VW'(SRC_H - 1));
  assign active   = (state != SYNC);
  assign accept   = p_valid && active && !last_seen;
  assign ovf_pix  = p_valid && active && last_seen;
  assign hit      = accept && (state == CAPTURE) && col_hit && row_hit;
  assign frame_end = f_done && (state == CAPTURE);
  // A pixel arriving with f_done still belongs to the frame that is closing.
  assign seen_now = last_seen || (accept && at_h_end && at_v_end);
  assign ovf_now  = ovf_frame || ovf_pix;

  logic [15:0] pix;
  logic [15:0] y_sum;
  logic [7:0]  y;
  logic [15:0] gray_data;

  assign pix = (BYTE_SWAP != 0) ? {p_data[7:0], p_data[15:8]} : p_data;
  assign y_sum = 16'd77  * {8'd0, pix[15:11], 3'b000}
               + 16'd150 * {8'd0, pix[10:5],  2'b00}
               + 16'd29  * {8'd0, pix[4:0],   3'b000};
  assign y = 8'(y_sum >> 8);
  assign gray_data = {y[7:3], y[7:2], y[7:3]};

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (f_done)            state_nxt = CAPTURE;
      CAPTURE: if (f_done && freeze)  state_nxt = FROZEN;
      FROZEN:  if (f_done && !freeze) state_nxt = CAPTURE;
      default:                        state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SYNC;
    else     state <= state_nxt;
  end

  // Address = row_base + col; row_base steps by WIN_W after each stored line.
  always_ff @(posedge clk) begin
    if (rst || f_done) begin
      h         <= '0;
      v         <= '0;
      col       <= '0;
      row_base  <= '0;
      last_seen <= 1'b0;
      ovf_frame <= 1'b0;
    end else if (accept) begin
      if (at_h_end) begin
        if (at_v_end) begin
          last_seen <= 1'b1;
        end else begin
          h   <= '0;
          v   <= v + VW'(1);
          col <= '0;
          if (row_hit) row_base <= row_base + ADDR_W'(WIN_W);
        end
      end else begin
        h <= h + HW'(1);
        if (col_hit) col <= col + ADDR_W'(1);
      end
    end else if (ovf_pix) begin
      ovf_frame <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_en   <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      w_en <= hit;
      if (hit) begin
        w_addr <= row_base + col;
        w_data <= gray_q ? gray_data : pix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_ready  <= 1'b0;
      frame_ok     <= 1'b0;
      frozen       <= 1'b0;
      err_overflow <= 1'b0;
      gray_q       <= 1'b0;
    end else begin
      frame_ready  <= frame_end;
      frame_ok     <= frame_end && seen_now && !ovf_now;
      frozen       <= (state_nxt == FROZEN);
      err_overflow <= err_overflow || ovf_pix;
      if (f_done) gray_q <= gray_en;
    end
  end

endmodule
